// File: rtl/ramio_bridge.sv
// RAMIO slave bridge: turns byte/half/word core accesses into word-wide,
// byte-strobed memory requests and decodes a single LED register.
module ramio_bridge #(
  parameter logic [31:0] MEM_BYTES = 32'h0080_0000,
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_FFFF,
  parameter int unsigned LED_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           write_type,
  input  logic [2:0]           read_type,
  input  logic [31:0]          address,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 data_out_ready,
  output logic                 busy,
  output logic                 err,
  output logic [LED_WIDTH-1:0] led,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic [1:0]           state_q, state_d;
  logic                 enable_q;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          data_out_q, data_out_d;
  logic                 dout_rdy_q, dout_rdy_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_wstrb_q, mem_wstrb_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [2:0]           rtype_q, rtype_d;
  logic [1:0]           off_q, off_d;
  logic                 io_rd_q, io_rd_d;
  logic                 io_err_q, io_err_d;
  logic [LED_WIDTH-1:0] io_wdata_q, io_wdata_d;

  logic                 is_wr_c;
  logic                 is_rd_c;
  logic [1:0]           size_c;
  logic                 misalign_c;
  logic                 is_led_c;
  logic                 bad_c;
  logic                 start_c;
  logic [3:0]           wstrb_c;
  logic [31:0]          wdata_c;
  logic [31:0]          rd_shift_c;
  logic [31:0]          rd_ext_c;

  // Request decode; a write always wins over a read.
  assign is_wr_c    = |write_type;
  assign is_rd_c    = |read_type[1:0];
  assign size_c     = is_wr_c ? write_type : read_type[1:0];
  assign misalign_c = ((size_c == SZ_HALF) && address[0]) ||
                      ((size_c == SZ_WORD) && (|address[1:0]));
  assign is_led_c   = (address == LED_ADDR);
  assign bad_c      = !is_led_c && (misalign_c || (address >= MEM_BYTES));
  assign start_c    = enable && !enable_q && !busy_q && (is_wr_c || is_rd_c);

  // Write lane steering.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    case (write_type)
      SZ_BYTE: begin
        wstrb_c = 4'b0001 << address[1:0];
        wdata_c = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        wstrb_c = address[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{data_in[15:0]}};
      end
      SZ_WORD: begin
        wstrb_c = 4'b1111;
        wdata_c = data_in;
      end
      default: ;
    endcase
  end

  // Read lane extraction and extension, using the offset captured at accept.
  always_comb begin
    rd_shift_c = mem_rdata >> {off_q, 3'b000};
    rd_ext_c   = 32'h0;
    case (rtype_q[1:0])
      SZ_BYTE: rd_ext_c = rtype_q[2] ? {{24{rd_shift_c[7]}}, rd_shift_c[7:0]}
                                     : {24'h0, rd_shift_c[7:0]};
      SZ_HALF: rd_ext_c = rtype_q[2] ? {{16{rd_shift_c[15]}}, rd_shift_c[15:0]}
                                     : {16'h0, rd_shift_c[15:0]};
      SZ_WORD: rd_ext_c = rd_shift_c;
      default: rd_ext_c = 32'h0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    err_d       = err_q;
    led_d       = led_q;
    data_out_d  = data_out_q;
    dout_rdy_d  = dout_rdy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rtype_d     = rtype_q;
    off_d       = off_q;
    io_rd_d     = io_rd_q;
    io_err_d    = io_err_q;
    io_wdata_d  = io_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          dout_rdy_d = 1'b0;
          busy_d     = 1'b1;
          rtype_d    = read_type;
          off_d      = address[1:0];
          io_rd_d    = !is_wr_c;
          if (is_led_c) begin
            state_d    = ST_IO;
            io_err_d   = 1'b0;
            io_wdata_d = data_in[LED_WIDTH-1:0];
          end else if (bad_c) begin
            // Error accesses reuse the one-cycle IO path without touching memory.
            state_d  = ST_IO;
            io_err_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d     = ST_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = is_wr_c;
            mem_addr_d  = {address[31:2], 2'b00};
            mem_wstrb_d = is_wr_c ? wstrb_c : 4'b0000;
            mem_wdata_d = is_wr_c ? wdata_c : 32'h0;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          if (!mem_we_q) begin
            data_out_d = rd_ext_c;
            dout_rdy_d = 1'b1;
          end
        end
      end
      ST_IO: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (io_rd_q) begin
          data_out_d = io_err_q ? 32'h0 : 32'(led_q);
          dout_rdy_d = 1'b1;
        end else if (!io_err_q) begin
          led_d = io_wdata_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= '0;
      data_out_q  <= 32'h0;
      dout_rdy_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rtype_q     <= 3'b000;
      off_q       <= 2'b00;
      io_rd_q     <= 1'b0;
      io_err_q    <= 1'b0;
      io_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      busy_q      <= busy_d;
      err_q       <= err_d;
      led_q       <= led_d;
      data_out_q  <= data_out_d;
      dout_rdy_q  <= dout_rdy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rtype_q     <= rtype_d;
      off_q       <= off_d;
      io_rd_q     <= io_rd_d;
      io_err_q    <= io_err_d;
      io_wdata_q  <= io_wdata_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_ready = dout_rdy_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign led            = led_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wstrb      = mem_wstrb_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_ramio_bridge.sv
// Scoreboard bench for ramio_bridge: expected memory requests and read results
// are queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_ramio_bridge;

  localparam logic [31:0] LED_A = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        err;
  logic [5:0]  led;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  ramio_bridge dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .write_type(write_type),
    .read_type(read_type), .address(address), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .err(err), .led(led), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          req_cnt  = 0;
  int          req_cyc  = 0;
  int          rdy_cyc  = 0;
  int          lat      = 3;
  int          mem_cnt  = 0;
  int          base     = 0;
  bit          stray    = 1'b0;
  logic        req_prev = 1'b0;
  logic        rdy_prev = 1'b0;
  logic [5:0]  idx;
  logic [31:0] mem_arr [0:63];
  req_t        exp_r, act_r;
  logic [31:0] exp_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack arrives lat cycles after the request is first seen.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mem_cnt = 0;
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (stray) begin
      stray   = 1'b0;
      mem_ack = 1'b1;
    end else if (mem_req) begin
      if (mem_cnt >= lat) begin
        mem_ack = 1'b1;
        idx = mem_addr[7:2];
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = mem_arr[idx];
        end
      end else begin
        mem_cnt = mem_cnt + 1;
      end
    end
  end

  // Monitor: compares each new memory request and each new read result.
  initial forever begin
    @(negedge clk);
    if (mem_req && !req_prev) begin
      req_cnt = req_cnt + 1;
      req_cyc = cyc;
      act_r = '{mem_we, mem_addr, mem_wstrb, mem_wdata};
      if (mem_q.size() == 0) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL unexpected_mem_req: got addr %h we %b expected none", mem_addr, mem_we);
      end else begin
        exp_r = mem_q.pop_front();
        if (!exp_r.we) begin
          act_r.wdata = 32'h0;
          exp_r.wdata = 32'h0;
        end
        check("mem_req_fields", 69'(act_r), 69'(exp_r));
      end
    end
    if (data_out_ready && !rdy_prev) begin
      rdy_cyc = cyc;
      if (rd_q.size() == 0) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL unexpected_read_result: got %h expected none", data_out);
      end else begin
        exp_d = rd_q.pop_front();
        check("read_data", 69'(data_out), 69'(exp_d));
      end
    end
    req_prev = mem_req;
    rdy_prev = data_out_ready;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (busy) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 100 cycles");
    end
  endtask

  task automatic wait_done();
    wait_idle();
    @(negedge clk);
  endtask

  // Presents one request; returns one negedge after the capturing edge.
  task automatic do_access(input logic [1:0] wt, input logic [2:0] rt,
                           input logic [31:0] a, input logic [31:0] d, input bit hold);
    wait_idle();
    write_type = wt;
    read_type  = rt;
    address    = a;
    data_in    = d;
    enable     = 1'b1;
    @(negedge clk);
    if (!hold) enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; write_type = 2'b00; read_type = 3'b000;
    address = 32'h0; data_in = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 69'(data_out), 69'(0));
    check("rst_ready", 69'(data_out_ready), 69'(0));
    check("rst_busy_err", 69'({busy, err}), 69'(0));
    check("rst_led", 69'(led), 69'(0));
    check("rst_mem", 69'({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}), 69'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Word write, then half read with 3-cycle memory latency.
    lat = 3;
    mem_q.push_back('{1'b1, 32'h4, 4'hF, 32'h1234_5537});
    do_access(2'b11, 3'b000, 32'h4, 32'h1234_5537, 1'b0);
    mem_q.push_back('{1'b0, 32'h4, 4'h0, 32'h0});
    rd_q.push_back(32'h0000_5537);
    do_access(2'b00, 3'b010, 32'h4, 32'h0, 1'b0);
    wait_done();
    check("latency_3", 69'(rdy_cyc - req_cyc), 69'(4));
    repeat (3) @(negedge clk);
    check("ready_holds", 69'({data_out_ready, data_out}), 69'({1'b1, 32'h0000_5537}));

    // Byte write to the top lane, then signed/unsigned extraction.
    lat = 1;
    mem_q.push_back('{1'b1, 32'h4, 4'b1000, 32'h8080_8080});
    do_access(2'b01, 3'b000, 32'h7, 32'h0000_0080, 1'b0);
    mem_q.push_back('{1'b0, 32'h4, 4'h0, 32'h0});
    rd_q.push_back(32'hFFFF_FF80);
    do_access(2'b00, 3'b101, 32'h7, 32'h0, 1'b0);
    wait_done();
    check("latency_1", 69'(rdy_cyc - req_cyc), 69'(2));
    mem_q.push_back('{1'b0, 32'h4, 4'h0, 32'h0});
    rd_q.push_back(32'h0000_0080);
    do_access(2'b00, 3'b001, 32'h7, 32'h0, 1'b0);
    mem_q.push_back('{1'b0, 32'h4, 4'h0, 32'h0});
    rd_q.push_back(32'hFFFF_8034);
    do_access(2'b00, 3'b110, 32'h6, 32'h0, 1'b0);
    mem_q.push_back('{1'b0, 32'h4, 4'h0, 32'h0});
    rd_q.push_back(32'h0000_0055);
    do_access(2'b00, 3'b001, 32'h5, 32'h0, 1'b0);
    mem_q.push_back('{1'b1, 32'h0, 4'b1100, 32'hBEEF_BEEF});
    do_access(2'b10, 3'b000, 32'h2, 32'h0000_BEEF, 1'b0);
    mem_q.push_back('{1'b1, 32'h007F_FFFC, 4'b1000, 32'hA5A5_A5A5});
    do_access(2'b01, 3'b000, 32'h007F_FFFF, 32'h0000_00A5, 1'b0);
    wait_done();
    check("err_clear", 69'(err), 69'(0));

    // Misaligned and out-of-range accesses.
    rd_q.push_back(32'h0);
    do_access(2'b00, 3'b010, 32'h3, 32'h0, 1'b0);
    wait_done();
    check("err_set", 69'(err), 69'(1));
    do_access(2'b11, 3'b000, 32'h2, 32'h1111_1111, 1'b0);
    rd_q.push_back(32'h0);
    do_access(2'b00, 3'b001, 32'h0080_0000, 32'h0, 1'b0);
    do_access(2'b01, 3'b000, 32'h0080_0004, 32'h0000_0077, 1'b0);
    mem_q.push_back('{1'b0, 32'h0, 4'h0, 32'h0});
    rd_q.push_back(32'hBEEF_0000);
    do_access(2'b00, 3'b011, 32'h0, 32'h0, 1'b0);
    wait_done();
    check("err_sticky", 69'(err), 69'(1));

    // LED register.
    do_access(2'b11, 3'b000, LED_A, 32'h0000_002A, 1'b0);
    check("led_busy_on", 69'(busy), 69'(1));
    @(negedge clk);
    check("led_busy_off", 69'(busy), 69'(0));
    check("led_write", 69'(led), 69'(6'h2A));
    rd_q.push_back(32'h0000_002A);
    do_access(2'b00, 3'b011, LED_A, 32'h0, 1'b0);
    do_access(2'b01, 3'b000, LED_A, 32'h1234_56C5, 1'b0);
    wait_done();
    check("led_byte_write", 69'(led), 69'(6'h05));
    rd_q.push_back(32'h0000_0005);
    do_access(2'b00, 3'b101, LED_A, 32'h0, 1'b0);
    wait_done();

    // Enable held high across completion, and an edge during busy.
    lat = 3;
    base = req_cnt;
    mem_q.push_back('{1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF});
    do_access(2'b11, 3'b000, 32'h8, 32'hDEAD_BEEF, 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);
    check("held_enable_once", 69'(req_cnt - base), 69'(1));
    enable = 1'b0;
    @(negedge clk);
    base = req_cnt;
    mem_q.push_back('{1'b0, 32'h8, 4'h0, 32'h0});
    rd_q.push_back(32'hDEAD_BEEF);
    do_access(2'b00, 3'b011, 32'h8, 32'h0, 1'b0);
    write_type = 2'b11; address = 32'hC; data_in = 32'h5555_5555;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("busy_edge_ignored", 69'(req_cnt - base), 69'(1));

    // Reset while a memory request is outstanding, then a stray ack.
    mem_q.push_back('{1'b0, 32'h8, 4'h0, 32'h0});
    do_access(2'b00, 3'b011, 32'h8, 32'h0, 1'b0);
    check("abort_req_up", 69'(mem_req), 69'(1));
    rst_n = 1'b0;
    #1;
    check("abort_rst_ctrl", 69'({mem_req, busy, data_out_ready, err}), 69'(0));
    check("abort_rst_data", 69'({data_out, led}), 69'(0));
    check("abort_rst_mem", 69'({mem_we, mem_addr, mem_wstrb, mem_wdata}), 69'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_ack_ignored", 69'({data_out_ready, busy, mem_req}), 69'(0));
    mem_q.push_back('{1'b0, 32'h8, 4'h0, 32'h0});
    rd_q.push_back(32'hDEAD_BEEF);
    do_access(2'b00, 3'b011, 32'h8, 32'h0, 1'b0);
    wait_done();

    check("mem_queue_drained", 69'(mem_q.size()), 69'(0));
    check("rd_queue_drained", 69'(rd_q.size()), 69'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
